// File: rtl/apb_stdout_reader.sv
// apb_stdout_reader
//   Host-side drain for the per-core stdout stream. Entries from the upstream
//   FWFT FIFO are pulled over a valid/ready handshake into a local prefetch
//   buffer. The host reads that buffer over APB, and a read of DATA pops the
//   entry it returns. Upstream overflow pulses are counted so the host can
//   see how many characters were lost.
//
// Ports
//   clk_i, rst_ni      clock; synchronous active-low reset
//   psel .. pslverr    APB slave (zero wait states, pready tied high)
//   entry_valid_i      upstream FIFO has data
//   entry_data_i       upstream head {8'b0, cluster, core, char}
//   entry_ready_o      pops the upstream head
//   overflow_i         one-cycle pulse per write rejected upstream
//
// Register map (paddr[11:2] decoded, 0x010..0xFFF -> pslverr)
//   0x00 DATA      RO  {valid, 7'b0, cluster, core, char}, pops on read
//   0x04 STATUS    RO  [15:0] count, [16] empty, [17] full, [18] ovf_sticky
//   0x08 CTRL      WO  [0] clear ovf_sticky, [1] flush buffer
//   0x0C DROP_CNT  RW  read drop count, any write clears it
module apb_stdout_reader #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  input  logic                  entry_valid_i,
  input  logic [31:0]           entry_data_i,
  output logic                  entry_ready_o,
  input  logic                  overflow_i
);

  localparam int unsigned PW = $clog2(DEPTH);

  // The top byte of an entry is always zero, so only the low 24 bits are kept.
  logic [23:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          ovf_sticky;
  logic [15:0]   drop_cnt;

  logic          access;
  logic          in_range;
  logic [1:0]    reg_sel;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          flush;
  logic          clr_ovf;
  logic          clr_drop;

  logic          unused_inputs;
  assign unused_inputs = ^{paddr[ADDR_WIDTH-1:12], paddr[1:0],
                           pwdata[DATA_WIDTH-1:2], entry_data_i[31:24]};

  assign access   = psel && penable;
  assign in_range = (paddr[11:4] == '0);
  assign reg_sel  = paddr[3:2];

  // count never exceeds DEPTH (a power of two), so its MSB alone means full.
  assign empty = (count == '0);
  assign full  = count[PW];

  assign pready        = 1'b1;
  assign entry_ready_o = rst_ni && !full;

  assign push     = entry_valid_i && entry_ready_o;
  assign pop      = access && in_range && !pwrite && (reg_sel == 2'd0) && !empty;
  assign flush    = access && in_range &&  pwrite && (reg_sel == 2'd2) && pwdata[1];
  assign clr_ovf  = access && in_range &&  pwrite && (reg_sel == 2'd2) && pwdata[0];
  assign clr_drop = access && in_range &&  pwrite && (reg_sel == 2'd3);

  always_comb begin
    prdata  = '0;
    pslverr = 1'b0;
    if (rst_ni && access) begin
      if (!in_range) begin
        pslverr = 1'b1;
      end else if (!pwrite) begin
        case (reg_sel)
          2'd0:    if (!empty) prdata = {1'b1, 7'b0, mem[rd_ptr]};
          2'd1:    prdata = {13'b0, ovf_sticky, full, empty, 16'(count)};
          2'd3:    prdata = {16'b0, drop_cnt};
          default: prdata = '0;
        endcase
      end
    end
  end

  // Storage is unreset; the pointers alone define which slots are live.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= entry_data_i[23:0];
  end

  // A flush concurrent with a push still completes the handshake, but the
  // accepted entry is dropped because the pointers are cleared.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A new overflow wins over a same-cycle host clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ovf_sticky <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      if (overflow_i)   ovf_sticky <= 1'b1;
      else if (clr_ovf) ovf_sticky <= 1'b0;

      if (clr_drop)                          drop_cnt <= {15'b0, overflow_i};
      else if (overflow_i && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_stdout_reader.sv
module tb_apb_stdout_reader;

  localparam int DEPTH = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;
  logic        entry_valid_i;
  logic [31:0] entry_data_i;
  logic        entry_ready_o;
  logic        overflow_i;

  always #5 clk_i = ~clk_i;

  apb_stdout_reader #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (DEPTH)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .psel          (psel),
    .penable       (penable),
    .pwrite        (pwrite),
    .paddr         (paddr),
    .pwdata        (pwdata),
    .prdata        (prdata),
    .pready        (pready),
    .pslverr       (pslverr),
    .entry_valid_i (entry_valid_i),
    .entry_data_i  (entry_data_i),
    .entry_ready_o (entry_ready_o),
    .overflow_i    (overflow_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: buffered entries in arrival order, sticky flag, drop count.
  logic [31:0] mq [$];
  logic        m_ovf;
  int          m_drop;

  typedef struct {
    logic        s, e, w;
    logic [31:0] a, wd;
    logic        ev;
    logic [31:0] ed;
    logic        ov;
    logic [31:0] x_rd;
    logic        x_err;
    logic        x_rdy;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ent(input int k);
    return {8'h00, 8'h5A, 8'(k), 8'(k * 7 + 3)};
  endfunction

  function automatic logic [31:0] xd(input logic [31:0] x);
    return {1'b1, 7'b0, x[23:0]};
  endfunction

  function automatic logic [31:0] m_rdata(input logic s, input logic e, input logic w,
                                          input logic [31:0] a);
    if (!(s && e) || w || a[11:4] != 8'h0) return 32'h0;
    case (a[3:2])
      2'd0:    return (mq.size() == 0) ? 32'h0 : xd(mq[0]);
      2'd1:    return {13'b0, m_ovf, mq.size() == DEPTH, mq.size() == 0, 16'(mq.size())};
      2'd3:    return {16'b0, 16'(m_drop)};
      default: return 32'h0;
    endcase
  endfunction

  // One clock: drive at negedge, compare against the model, advance the model.
  task automatic cyc(input logic s, input logic e, input logic w, input logic [31:0] a,
                     input logic [31:0] wd, input logic ev, input logic [31:0] ed,
                     input logic ov, output logic [31:0] rd, output logic err,
                     output logic rdy);
    logic [31:0] exp_rd;
    logic        exp_err, exp_rdy, acc, pop, push, flush;
    @(negedge clk_i);
    psel = s; penable = e; pwrite = w; paddr = a; pwdata = wd;
    entry_valid_i = ev; entry_data_i = ed; overflow_i = ov;
    #1;
    exp_rd  = m_rdata(s, e, w, a);
    exp_err = s && e && (a[11:4] != 8'h0);
    exp_rdy = (mq.size() < DEPTH);
    chk("model_prdata", prdata, exp_rd);
    chk("model_pslverr", 32'(pslverr), 32'(exp_err));
    chk("model_entry_ready", 32'(entry_ready_o), 32'(exp_rdy));
    rd = prdata; err = pslverr; rdy = entry_ready_o;

    acc   = s && e && (a[11:4] == 8'h0);
    pop   = acc && !w && a[3:2] == 2'd0 && mq.size() > 0;
    push  = ev && exp_rdy;
    flush = acc && w && a[3:2] == 2'd2 && wd[1];
    if (flush) mq.delete();
    else begin
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(ed);
    end
    if (ov) m_ovf = 1'b1;
    else if (acc && w && a[3:2] == 2'd2 && wd[0]) m_ovf = 1'b0;
    if (acc && w && a[3:2] == 2'd3) m_drop = ov ? 1 : 0;
    else if (ov && m_drop < 65535) m_drop++;
  endtask

  task automatic idle(input logic ev, input logic [31:0] ed, input logic ov, output logic rdy);
    logic [31:0] rd;
    logic        err;
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, ev, ed, ov, rd, err, rdy);
  endtask

  task automatic apb_rd(input logic [31:0] a, input logic ev, input logic [31:0] ed,
                        input logic ov, output logic [31:0] rd, output logic err,
                        output logic rdy);
    cyc(1'b1, 1'b0, 1'b0, a, 32'h0, 1'b0, 32'h0, 1'b0, rd, err, rdy);
    cyc(1'b1, 1'b1, 1'b0, a, 32'h0, ev, ed, ov, rd, err, rdy);
  endtask

  task automatic apb_wr(input logic [31:0] a, input logic [31:0] wd, input logic ev,
                        input logic [31:0] ed, input logic ov, output logic [31:0] rd,
                        output logic err, output logic rdy);
    cyc(1'b1, 1'b0, 1'b1, a, wd, 1'b0, 32'h0, 1'b0, rd, err, rdy);
    cyc(1'b1, 1'b1, 1'b1, a, wd, ev, ed, ov, rd, err, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    entry_valid_i = 1'b1; entry_data_i = 32'h00DE_ADBE; overflow_i = 1'b0;
    #1;
    chk("rst_entry_ready", 32'(entry_ready_o), 32'h0);
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_pslverr", 32'(pslverr), 32'h0);
    chk("rst_pready", 32'(pready), 32'h1);
    mq.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    entry_valid_i = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        err, rdy;
    int          up, rdi;

    rst_ni = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; entry_valid_i = 1'b0; entry_data_i = '0; overflow_i = 1'b0;
    m_ovf = 1'b0; m_drop = 0;
    do_reset();

    // Basic drain, error decode and CTRL read-as-zero from reset.
    //          s     e     w     a       wd     ev    ed             ov    x_rd           err   rdy
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 32'h0001_0241, 1'b0, 32'h0,         1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 32'h0001_020A, 1'b0, 32'h0,         1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,  32'h0, 1'b0, 32'h0,         1'b0, 32'h8001_0241, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,  32'h0, 1'b0, 32'h0,         1'b0, 32'h8001_020A, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,  32'h0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h4,  32'h0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h4,  32'h0, 1'b0, 32'h0,         1'b0, 32'h0001_0000, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 32'h8,  32'h1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 32'h8,  32'h1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 32'h8,  32'h0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 32'h8,  32'h0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1};

    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].s, tbl[i].e, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].ev, tbl[i].ed,
          tbl[i].ov, rd, err, rdy);
      chk($sformatf("vec%0d_prdata", i), rd, tbl[i].x_rd);
      chk($sformatf("vec%0d_pslverr", i), 32'(err), 32'(tbl[i].x_err));
      chk($sformatf("vec%0d_ready", i), 32'(rdy), 32'(tbl[i].x_rdy));
    end

    // Fill, backpressure, single-slot reopen and order across the wrap.
    up = 0;
    for (int c = 0; c < DEPTH + 2; c++) begin
      idle(1'b1, ent(up), 1'b0, rdy);
      if (rdy) up++;
    end
    chk("fill_accepts", 32'(up), 32'(DEPTH));
    idle(1'b1, ent(up), 1'b0, rdy);
    chk("full_ready", 32'(rdy), 32'h0);
    apb_rd(32'h4, 1'b0, 32'h0, 1'b0, rd, err, rdy);
    chk("full_status", rd, 32'h0002_0010);
    apb_rd(32'h0, 1'b1, ent(up), 1'b0, rd, err, rdy);
    chk("full_pop_data", rd, xd(ent(0)));
    chk("full_pop_ready", 32'(rdy), 32'h0);
    rdi = 1;
    idle(1'b1, ent(up), 1'b0, rdy);
    chk("one_slot_ready", 32'(rdy), 32'h1);
    if (rdy) up++;
    idle(1'b1, ent(up), 1'b0, rdy);
    chk("refull_ready", 32'(rdy), 32'h0);
    if (rdy) up++;
    for (int c = 0; c < 60 && rdi < DEPTH + 4; c++) begin
      apb_rd(32'h0, up < DEPTH + 4, ent(up), 1'b0, rd, err, rdy);
      if (rdy && up < DEPTH + 4) up++;
      chk($sformatf("wrap_order%0d", rdi), rd, xd(ent(rdi)));
      rdi++;
    end
    chk("wrap_all_read", 32'(rdi), 32'(DEPTH + 4));
    chk("wrap_all_pushed", 32'(up), 32'(DEPTH + 4));
    apb_rd(32'h4, 1'b0, 32'h0, 1'b0, rd, err, rdy);
    chk("drained_status", rd, 32'h0001_0000);

    // Concurrent push and pop at count = 1.
    idle(1'b1, 32'h0003_0455, 1'b0, rdy);
    apb_rd(32'h0, 1'b1, 32'h0003_0456, 1'b0, rd, err, rdy);
    chk("cc_old_head", rd, 32'h8003_0455);
    chk("cc_push_ready", 32'(rdy), 32'h1);
    apb_rd(32'h4, 1'b0, 32'h0, 1'b0, rd, err, rdy);
    chk("cc_count", rd, 32'h0000_0001);
    apb_rd(32'h0, 1'b0, 32'h0, 1'b0, rd, err, rdy);
    chk("cc_new_head", rd, 32'h8003_0456);

    // Flush with a concurrent push.
    for (int k = 0; k < 5; k++) idle(1'b1, 32'h0000_1100 + k, 1'b0, rdy);
    apb_rd(32'h4, 1'b0, 32'h0, 1'b0, rd, err, rdy);
    chk("flush_pre_count", rd, 32'h0000_0005);
    apb_wr(32'h8, 32'h2, 1'b1, 32'h00AA_BBCC, 1'b0, rd, err, rdy);
    chk("flush_push_ready", 32'(rdy), 32'h1);
    apb_rd(32'h4, 1'b0, 32'h0, 1'b0, rd, err, rdy);
    chk("flush_status", rd, 32'h0001_0000);
    apb_rd(32'h0, 1'b0, 32'h0, 1'b0, rd, err, rdy);
    chk("flush_data", rd, 32'h0);
    idle(1'b1, 32'h0007_0841, 1'b0, rdy);
    apb_rd(32'h0, 1'b0, 32'h0, 1'b0, rd, err, rdy);
    chk("flush_next_entry", rd, 32'h8007_0841);

    // Error decode, aliasing of paddr[1:0], no side effects out of range.
    idle(1'b1, 32'h0001_0203, 1'b0, rdy);
    apb_rd(32'h10, 1'b0, 32'h0, 1'b0, rd, err, rdy);
    chk("err_rd_data", rd, 32'h0);
    chk("err_rd_flag", 32'(err), 32'h1);
    apb_wr(32'h18, 32'h3, 1'b0, 32'h0, 1'b0, rd, err, rdy);
    chk("err_wr_flag", 32'(err), 32'h1);
    apb_rd(32'hFFC, 1'b0, 32'h0, 1'b0, rd, err, rdy);
    chk("err_top_flag", 32'(err), 32'h1);
    apb_rd(32'h6, 1'b0, 32'h0, 1'b0, rd, err, rdy);
    chk("alias_status", rd, 32'h0000_0001);
    apb_rd(32'h0, 1'b0, 32'h0, 1'b0, rd, err, rdy);
    chk("err_no_pop", rd, 32'h8001_0203);

    // Overflow tracking, clear races and saturation.
    for (int k = 0; k < 3; k++) idle(1'b0, 32'h0, 1'b1, rdy);
    apb_rd(32'h4, 1'b0, 32'h0, 1'b0, rd, err, rdy);
    chk("ovf_status", rd, 32'h0005_0000);
    apb_rd(32'hC, 1'b0, 32'h0, 1'b0, rd, err, rdy);
    chk("ovf_drop3", rd, 32'h3);
    apb_wr(32'h8, 32'h1, 1'b0, 32'h0, 1'b1, rd, err, rdy);
    apb_rd(32'h4, 1'b0, 32'h0, 1'b0, rd, err, rdy);
    chk("ovf_set_wins", rd, 32'h0005_0000);
    apb_rd(32'hC, 1'b0, 32'h0, 1'b0, rd, err, rdy);
    chk("ovf_drop4", rd, 32'h4);
    apb_wr(32'h8, 32'h1, 1'b0, 32'h0, 1'b0, rd, err, rdy);
    apb_rd(32'h4, 1'b0, 32'h0, 1'b0, rd, err, rdy);
    chk("ovf_cleared", rd, 32'h0001_0000);
    apb_wr(32'hC, 32'h0, 1'b0, 32'h0, 1'b0, rd, err, rdy);
    apb_rd(32'hC, 1'b0, 32'h0, 1'b0, rd, err, rdy);
    chk("drop_cleared", rd, 32'h0);
    apb_wr(32'hC, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1, rd, err, rdy);
    apb_rd(32'hC, 1'b0, 32'h0, 1'b0, rd, err, rdy);
    chk("drop_clear_race", rd, 32'h1);
    for (int k = 0; k < 70000; k++) idle(1'b0, 32'h0, 1'b1, rdy);
    apb_rd(32'hC, 1'b0, 32'h0, 1'b0, rd, err, rdy);
    chk("drop_saturate", rd, 32'h0000_FFFF);

    // Reset mid-operation with entries buffered and overflow flagged.
    for (int k = 0; k < 7; k++) idle(1'b1, ent(40 + k), 1'b0, rdy);
    apb_rd(32'h4, 1'b0, 32'h0, 1'b0, rd, err, rdy);
    chk("pre_reset_status", rd, 32'h0004_0007);
    do_reset();
    apb_rd(32'h4, 1'b0, 32'h0, 1'b0, rd, err, rdy);
    chk("post_reset_status", rd, 32'h0001_0000);
    apb_rd(32'hC, 1'b0, 32'h0, 1'b0, rd, err, rdy);
    chk("post_reset_drop", rd, 32'h0);
    apb_rd(32'h0, 1'b0, 32'h0, 1'b0, rd, err, rdy);
    chk("post_reset_data", rd, 32'h0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] a;
      int          pick;
      pick = $urandom_range(0, 9);
      if (pick < 4)      a = 32'(pick * 4) | 32'($urandom_range(0, 3));
      else if (pick < 7) a = 32'h0;
      else               a = $urandom & 32'h0000_0FFF;
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
          a, $urandom, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 7) == 0,
          rd, err, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
